multicycle_ctrl: RTL and testbench

// - Parametrised multicycle control FSM for the 4-bit-opcode core; successor to the single-cycle opcode decoder.
// - Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, drives the ALU op, memory handshake, register write and PC update.
// - Adds memory wait-states with a timeout fault, a halt state and optional performance counters.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 38 +++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control FSM: opcode map, ALU op codes,
// FSM states, PC source select and instruction classes.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SFT  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_BLT  = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LHB  = 4'd8;
  localparam logic [3:0] OP_STR  = 4'd9;
  localparam logic [3:0] OP_LIM  = 4'd10;
  localparam logic [3:0] OP_MVB  = 4'd11;
  localparam logic [3:0] OP_MVF  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_TBA  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SFL = 4'd2,
    ALU_SFR = 4'd3,
    ALU_INC = 4'd4,
    ALU_DEC = 4'd5,
    ALU_BNE = 4'd6,
    ALU_BEQ = 4'd7,
    ALU_BLT = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_BRANCH = 2'd2
  } pc_sel_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_BRANCH = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_MOVE   = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_NOP    = 3'd6,
    CLS_HALT   = 3'd7
  } instr_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the latched opcode and imm_flag to an
// instruction class (drives FSM routing) and the ALU operation.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imm_flag,
  output instr_class_e        iclass,
  output alu_op_e             alu_op
);

  always_comb begin
    iclass = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OPCODE_W'(OP_ADD):  begin iclass = CLS_ALU;    alu_op = ALU_ADD; end
      OPCODE_W'(OP_SUB):  begin iclass = CLS_ALU;    alu_op = ALU_SUB; end
      OPCODE_W'(OP_SFT):  begin iclass = CLS_ALU;    alu_op = imm_flag ? ALU_SFR : ALU_SFL; end
      OPCODE_W'(OP_INC):  begin iclass = CLS_ALU;    alu_op = imm_flag ? ALU_INC : ALU_DEC; end
      OPCODE_W'(OP_BNE):  begin iclass = CLS_BRANCH; alu_op = ALU_BNE; end
      OPCODE_W'(OP_BEQ):  begin iclass = CLS_BRANCH; alu_op = ALU_BEQ; end
      OPCODE_W'(OP_BLT):  begin iclass = CLS_BRANCH; alu_op = ALU_BLT; end
      OPCODE_W'(OP_LB):   iclass = CLS_LOAD;
      OPCODE_W'(OP_LHB):  iclass = CLS_LOAD;
      OPCODE_W'(OP_STR):  iclass = CLS_STORE;
      OPCODE_W'(OP_LIM):  iclass = CLS_MOVE;
      OPCODE_W'(OP_MVB):  iclass = CLS_MOVE;
      OPCODE_W'(OP_MVF):  iclass = CLS_MOVE;
      OPCODE_W'(OP_JMP):  iclass = CLS_JUMP;
      OPCODE_W'(OP_TBA):  iclass = CLS_NOP;
      OPCODE_W'(OP_HALT): iclass = CLS_HALT;
      default:            iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait-state
// timeout, sticky HALT/FAULT and optional perf counters (macro CTRL_PERF_EN).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] instr,
  input  logic                imm_flag,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_load,
  output logic [ALUOP_W-1:0]  alu_inst,
  output logic                reg_we,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                halted,
  output logic                fault,
  output logic [PERF_W-1:0]   retired_cnt,
  output logic [PERF_W-1:0]   cycle_cnt,
  output ctrl_state_e         state_dbg
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  ctrl_state_e         state;
  logic [OPCODE_W-1:0] op_q;
  logic                imm_q;
  logic [WAIT_W-1:0]   wait_cnt;
  instr_class_e        iclass;
  alu_op_e             alu_op;
  pc_sel_e             pc_sel_int;
  logic                mem_state;
  logic                timeout_hit;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (op_q),
    .imm_flag (imm_q),
    .iclass   (iclass),
    .alu_op   (alu_op)
  );

  assign mem_state = (state == ST_FETCH) || (state == ST_MEM);

  // Fault on the edge that closes the MEM_TIMEOUT-th consecutive wait cycle;
  // a mem_ready arriving in that same cycle completes the request instead.
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      imm_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            op_q  <= instr;
            imm_q <= imm_flag;
            state <= ST_DECODE;
          end else if (timeout_hit) begin
            state <= ST_FAULT;
          end
        end
        ST_DECODE: begin
          case (iclass)
            CLS_HALT:          state <= ST_HALT;
            CLS_JUMP, CLS_NOP: state <= ST_FETCH;
            CLS_MOVE:          state <= ST_WB;
            default:           state <= ST_EXEC;
          endcase
        end
        // Memory ops pass through EXEC for the address add before MEM.
        ST_EXEC: begin
          case (iclass)
            CLS_BRANCH:          state <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) state <= (iclass == CLS_STORE) ? ST_FETCH : ST_WB;
          else if (timeout_hit) state <= ST_FAULT;
        end
        ST_WB:    state <= ST_FETCH;
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase

      if ((MEM_TIMEOUT != 0) && mem_state && !mem_ready && !timeout_hit)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    pc_en      = 1'b0;
    pc_sel_int = PC_INC;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      ST_DECODE: begin
        if (iclass == CLS_JUMP) begin
          pc_en      = 1'b1;
          pc_sel_int = PC_JUMP;
        end else if (iclass == CLS_NOP) begin
          pc_en = 1'b1;
        end
      end
      ST_EXEC: begin
        if (iclass == CLS_BRANCH) begin
          pc_en      = 1'b1;
          pc_sel_int = branch_taken ? PC_BRANCH : PC_INC;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (iclass == CLS_STORE);
        pc_en   = (iclass == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign pc_sel    = pc_sel_int;
  assign alu_inst  = ALUOP_W'(alu_op);
  assign state_dbg = state;

`ifdef CTRL_PERF_EN
  logic [PERF_W-1:0] retired_q;
  logic [PERF_W-1:0] cycle_q;
  logic              counting;

  assign counting = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      cycle_q   <= '0;
    end else begin
      if (pc_en && !(&retired_q)) retired_q <= retired_q + PERF_W'(1);
      if (counting && !(&cycle_q)) cycle_q <= cycle_q + PERF_W'(1);
    end
  end

  assign retired_cnt = retired_q;
  assign cycle_cnt   = cycle_q;
`else
  assign retired_cnt = '0;
  assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random programs through a memory
// model, per-instruction expectations queued on fetch and checked at retire.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int EW = 20;

  typedef struct {
    logic [3:0] op;
    logic       imm;
    logic       bt;
    int         fw;
    int         mw;
  } ins_t;

  logic        clk, reset, start, imm_flag, mem_ready, branch_taken;
  logic [3:0]  instr;
  logic        mem_req, mem_we, ir_load, reg_we, pc_en, halted, fault;
  logic [3:0]  alu_inst;
  logic [1:0]  pc_sel;
  logic [31:0] retired_cnt, cycle_cnt;
  ctrl_state_e state_dbg;

  ins_t          prog[$];
  int            wait_q[$];
  logic [EW-1:0] exp_q[$];
  int            fetch_idx;
  int            mem_mode;
  logic          mon_en;
  int            mon_retires;
  int            checks, passes;

  multicycle_ctrl #(.OPCODE_W(4), .ALUOP_W(4), .MEM_TIMEOUT(4), .PERF_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .instr        (instr),
    .imm_flag     (imm_flag),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_load      (ir_load),
    .alu_inst     (alu_inst),
    .reg_we       (reg_we),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .halted       (halted),
    .fault        (fault),
    .retired_cnt  (retired_cnt),
    .cycle_cnt    (cycle_cnt),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: {latency, pc_sel, reg_we cycles, mem_we cycles, alu op}
  function automatic logic [EW-1:0] model(input ins_t i);
    int lat, rw, mwc;
    logic [1:0] sel;
    logic [3:0] alu;
    lat = i.fw + 1;
    sel = 2'd0; rw = 0; mwc = 0; alu = 4'd0;
    case (i.op)
      OP_JMP: begin lat += 1; sel = 2'd1; end
      OP_TBA: lat += 1;
      OP_BNE, OP_BEQ, OP_BLT: begin lat += 2; sel = i.bt ? 2'd2 : 2'd0; end
      OP_ADD, OP_SUB, OP_SFT, OP_INC: begin lat += 3; rw = 1; end
      OP_LIM, OP_MVB, OP_MVF: begin lat += 2; rw = 1; end
      OP_LB, OP_LHB: begin lat += i.mw + 4; rw = 1; end
      OP_STR: begin lat += i.mw + 3; mwc = i.mw + 1; end
      default: ;
    endcase
    case (i.op)
      OP_SUB: alu = 4'd1;
      OP_SFT: alu = i.imm ? 4'd3 : 4'd2;
      OP_INC: alu = i.imm ? 4'd4 : 4'd5;
      OP_BNE: alu = 4'd6;
      OP_BEQ: alu = 4'd7;
      OP_BLT: alu = 4'd8;
      default: alu = 4'd0;
    endcase
    return {lat[7:0], sel, rw[1:0], mwc[3:0], alu};
  endfunction

  function automatic bit is_mem_op(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LHB) || (op == OP_STR);
  endfunction

  task automatic add_ins(input logic [3:0] op, input logic imm, input logic bt, input int fw, input int mw);
    ins_t i;
    i.op = op; i.imm = imm; i.bt = bt; i.fw = fw; i.mw = mw;
    prog.push_back(i);
    wait_q.push_back(fw);
    if (is_mem_op(op)) wait_q.push_back(mw);
  endtask

  // Memory/instruction driver: inputs change 1ns after posedge.
  initial begin : mem_driver
    int   age, cur_wait;
    logic in_req;
    mem_ready = 1'b0; instr = 4'd0; imm_flag = 1'b0; branch_taken = 1'b0;
    in_req = 1'b0; age = 0; cur_wait = 0;
    forever begin
      @(posedge clk); #1;
      if (in_req && mem_ready) in_req = 1'b0;
      else if (in_req) age++;
      if (!mem_req) in_req = 1'b0;
      if (mem_req && !in_req) begin
        in_req = 1'b1;
        age = 0;
        cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      end
      if (mem_req) mem_ready = (mem_mode == 0) && (age >= cur_wait);
      else mem_ready = 1'($urandom_range(0, 1));
      if (fetch_idx < prog.size()) begin
        instr = prog[fetch_idx].op;
        imm_flag = prog[fetch_idx].imm;
      end else begin
        instr = OP_HALT;
        imm_flag = 1'($urandom_range(0, 1));
      end
      if (fetch_idx > 0 && fetch_idx <= prog.size()) branch_taken = prog[fetch_idx-1].bt;
      else branch_taken = 1'($urandom_range(0, 1));
      #1;
      if (ir_load && fetch_idx < prog.size()) begin
        if (prog[fetch_idx].op != OP_HALT) exp_q.push_back(model(prog[fetch_idx]));
        fetch_idx++;
      end
    end
  end

  // Monitor / scoreboard: samples on negedge, compares at every retire.
  initial begin : monitor
    logic [EW-1:0] e;
    int   lat, rw, mwc;
    logic in_instr;
    in_instr = 1'b0; lat = 0; rw = 0; mwc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) in_instr = 1'b0;
      else begin
        if (!in_instr && mem_req) begin
          in_instr = 1'b1; lat = 0; rw = 0; mwc = 0;
        end
        if (in_instr) begin
          lat++;
          rw  += int'(reg_we);
          mwc += int'(mem_we);
          if (pc_en) begin
            check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("latency", lat, 32'(e[19:12]));
              check("pc_sel", 32'(pc_sel), 32'(e[11:10]));
              check("reg_we_cycles", rw, 32'(e[9:8]));
              check("mem_we_cycles", mwc, 32'(e[7:4]));
              check("alu_inst", 32'(alu_inst), 32'(e[3:0]));
            end
            mon_retires++;
            in_instr = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    start = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] strobes();
    return {24'd0, halted, fault, mem_req, mem_we, ir_load, reg_we, pc_en, |pc_sel};
  endfunction

  initial begin : main
    int n_exp, cnt, exp_ret, exp_cyc;
    checks = 0; passes = 0; mon_retires = 0; fetch_idx = 0; mem_mode = 0;
    mon_en = 1'b0; start = 1'b0; reset = 1'b1;
`ifdef CTRL_PERF_EN
    exp_ret = 3; exp_cyc = 11;
`else
    exp_ret = 0; exp_cyc = 0;
`endif

    tick(); tick(); tick();
    @(negedge clk);
    check("reset_strobes", strobes(), 32'd0);
    check("reset_alu_inst", 32'(alu_inst), 32'd0);
    check("reset_counters", retired_cnt | cycle_cnt, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("idle_without_start", 32'(state_dbg), 32'(ST_IDLE));

    // Directed prefix then a random program ending in HALT
    add_ins(OP_ADD, 1'b0, 1'b0, 0, 0);
    add_ins(OP_JMP, 1'b0, 1'b0, 0, 0);
    add_ins(OP_LB,  1'b0, 1'b0, 0, 0);
    add_ins(OP_BEQ, 1'b0, 1'b1, 0, 0);
    add_ins(OP_BNE, 1'b0, 1'b0, 0, 0);
    add_ins(OP_STR, 1'b0, 1'b0, 0, 3);
    add_ins(OP_SFT, 1'b1, 1'b0, 3, 0);
    add_ins(OP_INC, 1'b0, 1'b0, 1, 0);
    for (int k = 0; k < 60; k++)
      add_ins(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    add_ins(OP_HALT, 1'b0, 1'b0, 0, 0);
    n_exp = prog.size() - 1;

    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && mon_retires < 3; c++) tick();
    @(negedge clk);
    check("perf_retired_after_3", retired_cnt, 32'(exp_ret));
    check("perf_cycles_after_3", cycle_cnt, 32'(exp_cyc));

    for (int c = 0; c < 4000 && !(mon_retires == n_exp && halted); c++) begin
      tick();
      start = 1'($urandom_range(0, 1));
    end
    check("all_retired", mon_retires, n_exp);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("halted_after_program", 32'(halted), 32'd1);

    for (int c = 0; c < 20; c++) begin
      tick();
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_sticky", strobes(), 32'h80);
    end

    do_reset();
    @(negedge clk);
    check("reset_clears_halt", strobes(), 32'd0);
    check("reset_clears_counters", retired_cnt | cycle_cnt, 32'd0);

    // Timeout: memory never answers the fetch
    prog.delete(); wait_q.delete(); exp_q.delete(); fetch_idx = 0;
    mem_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40 && !fault; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      tick();
    end
    @(negedge clk);
    check("timeout_wait_cycles", cnt, 32'd4);
    check("fault_state", strobes(), 32'h40);
    tick(); tick();
    @(negedge clk);
    check("fault_sticky", strobes(), 32'h40);
    do_reset();
    @(negedge clk);
    check("reset_clears_fault", strobes(), 32'd0);

    // Reset in the middle of a load's memory phase
    mem_mode = 0;
    add_ins(OP_LB, 1'b0, 1'b0, 0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !(fetch_idx == 1 && mem_req && !ir_load); c++) tick();
    check("lb_in_mem", 32'(state_dbg), 32'(ST_MEM));
    check("lb_mem_we_low", 32'(mem_we), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_mem_reset_mem_req", 32'(mem_req), 32'd0);
    check("mid_mem_reset_state", 32'(state_dbg), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
